// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage that feeds the control unit. It holds the program
//   counter and an instruction memory. The memory is loaded while the stage is
//   in LOAD. After i_start, the stage presents one instruction at a time. It
//   moves on to PC+1, or to PC+offset for a taken branch, on each rising edge
//   of the i_PC strobe from control.
//
// Ports
//   clk            in   1        system clock, rising edge
//   reset          in   1        asynchronous, active-low reset
//   i_load_en      in   1        write i_load_data to memory (LOAD state only)
//   i_load_addr    in   ADDR_W   program load address
//   i_load_data    in   INSTR_W  program load word
//   i_start        in   1        leave LOAD and begin fetching at PC=0
//   i_PC           in   1        advance strobe; only its rising edge acts
//   i_PCop         in   1        1: PC + sext(i_branch), 0: PC + 1
//   i_branch       in   OFF_W    two's-complement branch offset
//   o_instruction  out  INSTR_W  current instruction
//   o_pc           out  ADDR_W   address of o_instruction
//   o_valid        out  1        o_instruction is stable and matches o_pc
//   o_running      out  1        fetch active (not in LOAD)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 13,
  parameter int OFF_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load_en,
  input  logic [ADDR_W-1:0]  i_load_addr,
  input  logic [INSTR_W-1:0] i_load_data,
  input  logic               i_start,
  input  logic               i_PC,
  input  logic               i_PCop,
  input  logic [OFF_W-1:0]   i_branch,
  output logic [INSTR_W-1:0] o_instruction,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_valid,
  output logic               o_running
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_d;

  logic [INSTR_W-1:0] mem [DEPTH];

  logic               strobe_q;
  logic               adv;
  logic               pending, pending_d;
  logic               pend_op, pend_op_d;
  logic [OFF_W-1:0]   pend_branch, pend_branch_d;

  logic [ADDR_W-1:0]  pc_d;
  logic [INSTR_W-1:0] instr_d;
  logic               valid_d;
  logic               running_d;

  logic               sel_op;
  logic [OFF_W-1:0]   sel_branch;
  logic [ADDR_W-1:0]  offset_ext;
  logic [ADDR_W-1:0]  next_pc;

  // The program memory has no reset. Its contents survive a reset, and it can
  // only be written while the stage is in LOAD.
  always_ff @(posedge clk) begin
    if (state == LOAD && i_load_en) begin
      mem[i_load_addr] <= i_load_data;
    end
  end

  // A strobe that arrives during ISSUE is stored in pending. The PC step then
  // comes from the op and offset captured with it, not from the live inputs.
  // The adder is only ADDR_W bits wide, so the PC wraps around in both
  // directions.
  always_comb begin
    adv        = i_PC & ~strobe_q;
    sel_op     = pending ? pend_op : i_PCop;
    sel_branch = pending ? pend_branch : i_branch;
    offset_ext = {{(ADDR_W - OFF_W){sel_branch[OFF_W-1]}}, sel_branch};
    next_pc    = sel_op ? (o_pc + offset_ext) : (o_pc + ADDR_W'(1));
  end

  always_comb begin
    state_d       = state;
    pc_d          = o_pc;
    instr_d       = o_instruction;
    valid_d       = o_valid;
    running_d     = o_running;
    pending_d     = pending;
    pend_op_d     = pend_op;
    pend_branch_d = pend_branch;

    case (state)
      LOAD: begin
        if (i_start) begin
          state_d   = ISSUE;
          running_d = 1'b1;
        end
      end

      ISSUE: begin
        instr_d = mem[o_pc];
        valid_d = 1'b1;
        state_d = HOLD;
        if (adv) begin
          pending_d     = 1'b1;
          pend_op_d     = i_PCop;
          pend_branch_d = i_branch;
        end
      end

      HOLD: begin
        if (adv || pending) begin
          pc_d      = next_pc;
          valid_d   = 1'b0;
          pending_d = 1'b0;
          state_d   = ISSUE;
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // The edge-detect register samples i_PC in every state. Because of this, a
  // level that rises while the stage is loading does not count as an advance
  // later on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= LOAD;
      o_pc          <= '0;
      o_instruction <= '0;
      o_valid       <= 1'b0;
      o_running     <= 1'b0;
      strobe_q      <= 1'b0;
      pending       <= 1'b0;
      pend_op       <= 1'b0;
      pend_branch   <= '0;
    end else begin
      state         <= state_d;
      o_pc          <= pc_d;
      o_instruction <= instr_d;
      o_valid       <= valid_d;
      o_running     <= running_d;
      strobe_q      <= i_PC;
      pending       <= pending_d;
      pend_op       <= pend_op_d;
      pend_branch   <= pend_branch_d;
    end
  end

endmodule
